// File: rtl/seg_serial_ctrl.sv
// Serial sequencer for the 8-digit display chain: captures a segment frame and shifts it MSB first.
// Optional build macro SEG_AUTO_REFRESH_EN adds a free-running periodic frame request.
module seg_serial_ctrl #(
    parameter int unsigned HALF_DIV = 4,
    parameter int unsigned NBITS    = 64
`ifdef SEG_AUTO_REFRESH_EN
    ,
    parameter int unsigned REFRESH  = 1048576
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] seg_data,
    output logic             busy,
    output logic             done,
    output logic             seg_clk,
    output logic             seg_sout,
    output logic             seg_pen,
    output logic             seg_clrn
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [5:0] LAST_BIT = 6'(NBITS - 1);

    state_e           state_r, state_n;
    logic [NBITS-1:0] shreg_r, shreg_n;
    logic [5:0]       bit_cnt_r, bit_cnt_n;
    logic [7:0]       div_r, div_n;
    logic             pending_r, pending_n;
    logic             seg_clk_r, seg_clk_n;
    logic             sout_r, sout_n;
    logic             pen_r, pen_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;
    logic             clrn_r;
    logic             req_s;

`ifdef SEG_AUTO_REFRESH_EN
    logic [31:0] refresh_r;
    logic        auto_s;

    assign auto_s = (refresh_r == 32'(REFRESH - 1));
    assign req_s  = start | auto_s;

    // Free-running refresh timer, independent of the frame state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_r <= 32'd0;
        end else if (auto_s) begin
            refresh_r <= 32'd0;
        end else begin
            refresh_r <= refresh_r + 32'd1;
        end
    end
`else
    assign req_s = start;
`endif

    // Next-state and next-output logic; outputs are registered so each value lines up with its state
    always_comb begin
        state_n   = state_r;
        shreg_n   = shreg_r;
        bit_cnt_n = bit_cnt_r;
        div_n     = div_r;
        pending_n = pending_r;
        seg_clk_n = seg_clk_r;
        sout_n    = sout_r;
        pen_n     = pen_r;
        busy_n    = busy_r;
        done_n    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_n   = LOAD;
                    shreg_n   = seg_data;
                    sout_n    = seg_data[NBITS-1];
                    pen_n     = 1'b0;
                    busy_n    = 1'b1;
                    bit_cnt_n = 6'd0;
                    div_n     = 8'd0;
                    seg_clk_n = 1'b0;
                end else begin
                    busy_n = 1'b0;
                end
            end
            LOAD: begin
                pending_n = pending_r | req_s;
                state_n   = SHIFT_LO;
                seg_clk_n = 1'b0;
                div_n     = 8'd0;
            end
            SHIFT_LO: begin
                pending_n = pending_r | req_s;
                if (div_r == DIV_LAST) begin
                    div_n     = 8'd0;
                    seg_clk_n = 1'b1;
                    state_n   = SHIFT_HI;
                end else begin
                    div_n = div_r + 8'd1;
                end
            end
            SHIFT_HI: begin
                pending_n = pending_r | req_s;
                if (div_r == DIV_LAST) begin
                    div_n     = 8'd0;
                    seg_clk_n = 1'b0;
                    shreg_n   = {shreg_r[NBITS-2:0], 1'b0};
                    if (bit_cnt_r == LAST_BIT) begin
                        state_n = LATCH;
                        pen_n   = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        // next bit appears on the same edge seg_clk falls
                        bit_cnt_n = bit_cnt_r + 6'd1;
                        sout_n    = shreg_r[NBITS-2];
                        state_n   = SHIFT_LO;
                    end
                end else begin
                    div_n = div_r + 8'd1;
                end
            end
            LATCH: begin
                pending_n = 1'b0;
                if (pending_r | req_s) begin
                    state_n   = LOAD;
                    shreg_n   = seg_data;
                    sout_n    = seg_data[NBITS-1];
                    pen_n     = 1'b0;
                    busy_n    = 1'b1;
                    bit_cnt_n = 6'd0;
                    div_n     = 8'd0;
                end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n   = IDLE;
                busy_n    = 1'b0;
                seg_clk_n = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shreg_r   <= '0;
            bit_cnt_r <= 6'd0;
            div_r     <= 8'd0;
            pending_r <= 1'b0;
            seg_clk_r <= 1'b0;
            sout_r    <= 1'b0;
            pen_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            clrn_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            shreg_r   <= shreg_n;
            bit_cnt_r <= bit_cnt_n;
            div_r     <= div_n;
            pending_r <= pending_n;
            seg_clk_r <= seg_clk_n;
            sout_r    <= sout_n;
            pen_r     <= pen_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            clrn_r    <= 1'b1;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign seg_clk  = seg_clk_r;
    assign seg_sout = sout_r;
    assign seg_pen  = pen_r;
    assign seg_clrn = clrn_r;

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// Self-checking bench for seg_serial_ctrl: reset vector table, frame serialisation against an
// MSB-first reference, pending/merge behaviour, mid-frame reset and the HALF_DIV=1 corner.
module tb_seg_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] seg_data;
    logic        sel;

    logic b4, d4, c4, s4, p4, r4;
    logic b1, d1, c1, s1, p1, r1;
    logic busy_m, done_m, clk_m, sout_m, pen_m, clrn_m;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seg_serial_ctrl #(.HALF_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .seg_data(seg_data),
        .busy(b4), .done(d4), .seg_clk(c4), .seg_sout(s4), .seg_pen(p4), .seg_clrn(r4)
    );

    seg_serial_ctrl #(.HALF_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .seg_data(seg_data),
        .busy(b1), .done(d1), .seg_clk(c1), .seg_sout(s1), .seg_pen(p1), .seg_clrn(r1)
    );

    assign busy_m = sel ? b1 : b4;
    assign done_m = sel ? d1 : d4;
    assign clk_m  = sel ? c1 : c4;
    assign sout_m = sel ? s1 : s4;
    assign pen_m  = sel ? p1 : p4;
    assign clrn_m = sel ? r1 : r4;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a frame is the captured word sent MSB first on seg_clk rising edges,
    // done arrives 2 + 128*HALF_DIV edges after the launching edge.
    // mode 0: plain; mode 1: three start pulses mid-frame with new data; mode 2: start in LATCH cycle.
    task automatic frame_check(input string tag, input logic [63:0] exp_data, input int exp_lat,
                               input int mode, input logic [63:0] new_data);
        int          cnt, rises, busy_gaps, pen_bad, stab_bad;
        logic [63:0] got;
        logic        pc, ps, done_seen;
        cnt = 0; rises = 0; busy_gaps = 0; pen_bad = 0; stab_bad = 0;
        got = 64'd0; pc = clk_m; ps = sout_m; done_seen = 1'b0;
        while (cnt < exp_lat + 50) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            start = (mode == 1) && (cnt == 100 || cnt == 150 || cnt == 300);
            if (mode == 1 && cnt == 100) seg_data = new_data;
            if (!busy_m) busy_gaps++;
            if (clk_m && !pc) begin
                got = {got[62:0], sout_m};
                rises++;
            end
            if (clk_m && pc && (sout_m !== ps)) stab_bad++;
            if (pen_m && !done_m) pen_bad++;
            pc = clk_m;
            ps = sout_m;
            if (done_m) begin
                done_seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(done_seen), 64'd1);
        chk({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
        chk({tag, "_rises"}, 64'(rises), 64'd64);
        chk({tag, "_data"}, got, exp_data);
        chk({tag, "_busy_gaps"}, 64'(busy_gaps), 64'd0);
        chk({tag, "_pen_during_shift"}, 64'(pen_bad), 64'd0);
        chk({tag, "_sout_stable_hi"}, 64'(stab_bad), 64'd0);
        chk({tag, "_pen_at_done"}, {62'd0, pen_m, clk_m}, 64'd2);
        if (mode == 2) begin
            start    = 1'b1;
            seg_data = new_data;
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        int busy_hi, clk_hi;
        busy_hi = 0; clk_hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy_m) busy_hi++;
            if (clk_m) clk_hi++;
        end
        chk({tag, "_no_busy"}, 64'(busy_hi), 64'd0);
        chk({tag, "_no_seg_clk"}, 64'(clk_hi), 64'd0);
    endtask

    typedef struct {
        logic       rst_n;
        logic       start;
        logic [5:0] exp;   // {busy, done, seg_clk, seg_sout, seg_pen, seg_clrn}
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [63:0] data, data2;
        int          rises, wait_cnt;
        logic        pc;

        rst_n = 1'b0; start = 1'b0; sel = 1'b0;
        seg_data = 64'h8000_0000_0000_0001;

        tbl[0]  = '{1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b0, 1'b1, 6'b000000};
        tbl[2]  = '{1'b1, 1'b0, 6'b000001};
        tbl[3]  = '{1'b1, 1'b0, 6'b000001};
        tbl[4]  = '{1'b1, 1'b1, 6'b100101};
        tbl[5]  = '{1'b1, 1'b0, 6'b100101};
        tbl[6]  = '{1'b1, 1'b0, 6'b100101};
        tbl[7]  = '{1'b1, 1'b0, 6'b100101};
        tbl[8]  = '{1'b1, 1'b0, 6'b100101};
        tbl[9]  = '{1'b1, 1'b0, 6'b101101};
        tbl[10] = '{1'b0, 1'b0, 6'b000000};
        tbl[11] = '{1'b1, 1'b0, 6'b000001};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            rst_n = tbl[i].rst_n;
            start = tbl[i].start;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t1_row%0d", i),
                {58'd0, busy_m, done_m, clk_m, sout_m, pen_m, clrn_m}, {58'd0, tbl[i].exp});
        end
        start = 1'b0;
        @(negedge clk);

        // single frame
        seg_data = 64'hF0F0_0000_1234_ABCD;
        start = 1'b1;
        frame_check("t2", 64'hF0F0_0000_1234_ABCD, 514, 0, 64'd0);
        idle_check("t2_idle", 10);

        // pending requests merge into exactly one extra frame with the new data
        seg_data = 64'h0123_4567_89AB_CDEF;
        start = 1'b1;
        frame_check("t3a", 64'h0123_4567_89AB_CDEF, 514, 1, 64'd0);
        frame_check("t3b", 64'd0, 514, 0, 64'd0);
        idle_check("t3_idle", 20);

        // start arriving in the LATCH cycle launches the next frame
        seg_data = 64'hDEAD_BEEF_0000_FFFF;
        start = 1'b1;
        frame_check("t7a", 64'hDEAD_BEEF_0000_FFFF, 514, 2, 64'h5A5A_C3C3_1111_8001);
        frame_check("t7b", 64'h5A5A_C3C3_1111_8001, 514, 0, 64'd0);

        // randomized frames with random idle gaps
        for (int i = 0; i < 4; i++) begin
            data = {$urandom, $urandom};
            repeat ($urandom_range(0, 5)) @(negedge clk);
            seg_data = data;
            start = 1'b1;
            frame_check($sformatf("rnd%0d", i), data, 514, 0, 64'd0);
        end
        idle_check("rnd_idle", 5);

        // reset in the middle of a frame
        seg_data = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rises = 0; pc = clk_m;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (clk_m && !pc) rises++;
            pc = clk_m;
            if (rises == 30) break;
        end
        chk("t4_reached_bit30", 64'(rises), 64'd30);
        #2 rst_n = 1'b0;
        #1 chk("t4_async_reset", {58'd0, busy_m, done_m, clk_m, sout_m, pen_m, clrn_m}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_clrn_pen", {62'd0, clrn_m, pen_m}, 64'd2);
        data2 = {$urandom, $urandom};
        seg_data = data2;
        start = 1'b1;
        frame_check("t4", data2, 514, 0, 64'd0);
        idle_check("t4_idle", 5);

        // HALF_DIV=1 corner on the second instance
        sel = 1'b1;
        seg_data = 64'hAAAA_AAAA_AAAA_AAAA;
        start = 1'b1;
        frame_check("t5", 64'hAAAA_AAAA_AAAA_AAAA, 130, 0, 64'd0);
        sel = 1'b0;
        wait_cnt = 0;
        while (b4 && wait_cnt < 600) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("t5_div4_drained", 64'(b4), 64'd0);

        // no frame is ever launched without a request
        idle_check("t6_no_auto", 1100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
